cpu_run_ctrl: RTL
=================

// Module: cpu_run_ctrl
// PURPOSE
//  Hardware run/step/halt controller for the cpu core; replaces bench-driven clock toggling.
//  Drives a per-cycle enable into the cpu and stops execution on cpu halt, step-count
//  expiry, PC breakpoint match or host stop. Sits between a host command port and the cpu.
// PARAMETERS
//  PC_WIDTH     16  width of cpu pc / breakpoint addresses
//  CNT_WIDTH    32  width of step counter and retired-cycle counter
//  NUM_BP       4   number of PC breakpoint comparators (1..16)
//  WDOG_CYCLES  1024  watchdog limit, used only with CPU_RUN_WDOG_EN
// PORTS
//  CLK          in   1          system clock, rising edge
//  RST          in   1          asynchronous reset, active-high
//  cmd_valid    in   1          host command valid
//  cmd_ready    out  1          controller accepts command (1 only when not RUN/STEP)
//  cmd_op       in   2          0=RUN 1=STEP 2=STOP 3=CLR_CNT
//  cmd_steps    in   CNT_WIDTH  cycle count for STEP (0 treated as 1)
//  bp_we        in   1          breakpoint write strobe (accepted in any state)
//  bp_idx       in   $clog2(NUM_BP)  breakpoint slot
//  bp_addr      in   PC_WIDTH   breakpoint PC
//  bp_on        in   1          slot enable
//  cpu_pc       in   PC_WIDTH   current cpu pc
//  cpu_halted   in   1          cpu halted flag
//  cpu_en       out  1          cpu advances one instruction on CLK edge when 1
//  running      out  1          state is RUN or STEP
//  stop_pulse   out  1          one-cycle pulse on entering STOPPED
//  stop_reason  out  3          0=none 1=halt 2=step_done 3=breakpoint 4=host_stop 5=watchdog
//  cycle_cnt    out  CNT_WIDTH  cycles with cpu_en=1 since reset/CLR_CNT, saturating
// BEHAVIOUR
//  Reset: state=IDLE, cpu_en=0, running=0, stop_pulse=0, stop_reason=0, cycle_cnt=0,
//   all bp slots disabled, bp addrs 0. cmd_ready=1.
//  FSM states IDLE, RUN, STEP, STOPPED. Command handshake: accepted on cycle with
//   cmd_valid & cmd_ready. Exception: STOP accepted in any state (cmd_ready ignored for it).
//  IDLE/STOPPED: RUN -> RUN; STEP -> STEP with remaining=max(cmd_steps,1); STOP -> no-op;
//   CLR_CNT -> cycle_cnt=0 next cycle, state unchanged.
//  Start rule: if cpu_halted=1 when RUN/STEP accepted -> go straight to STOPPED, reason=1,
//   cpu_en never asserted.
//  cpu_en is combinational: 1 iff state in {RUN,STEP} and no stop condition this cycle.
//   Latency: command accepted at edge N -> first cpu_en-qualified edge N+1.
//  Stop conditions evaluated each cycle in RUN/STEP, priority high->low:
//   host STOP(4) > cpu_halted(1) > breakpoint(3) > watchdog(5) > step_done(2).
//   Breakpoint: any enabled slot with bp_addr==cpu_pc; checked before the instruction at
//   that pc executes (cpu_en=0 that cycle). Breakpoint match ignored on the first enabled
//   cycle after start, so RUN resumes past the breakpoint it stopped on.
//   step_done: remaining==1 and this cycle enables cpu; cpu_en=1 on that cycle, then STOPPED.
//  On stop: state=STOPPED, stop_reason latched, stop_pulse=1 for exactly one cycle.
//   stop_reason holds until next RUN/STEP accepted (then cleared to 0).
//  cycle_cnt increments on every edge with cpu_en=1; saturates at all-ones, no wrap.
//  Simultaneous bp_we and bp match on same slot: match uses old value; new value next cycle.
//  Simultaneous CLR_CNT and increment impossible (CLR_CNT only accepted when not running).
//  RST mid-RUN: immediate return to reset values; cpu_en drops asynchronously.
// CONFIGURATION
//  CPU_RUN_WDOG_EN defined: a counter of consecutive cpu_en cycles since last RUN/STEP start;
//   reaching WDOG_CYCLES stops with reason 5 (cpu_en=0 on the limit cycle).
//  CPU_RUN_WDOG_EN undefined: no watchdog logic; reason 5 never produced; WDOG_CYCLES unused.
// TESTING
//  1 RST, cpu_halted=1, RUN -> STOPPED next cycle, reason=1, cpu_en never 1, cycle_cnt=0.
//  2 STEP cmd_steps=3 on non-halting prog -> cpu_en high exactly 3 cycles, reason=2, cycle_cnt=3, one stop_pulse.
//  3 bp slot0=0x0002 on, RUN from pc 0 -> stop with cpu_pc=2, reason=3, cycle_cnt=2; RUN again passes pc 2.
//  4 STOP issued during RUN at cycle 5 -> cpu_en 0 that cycle, reason=4; STEP cmd_steps=0 -> exactly 1 cycle.
//  5 add prog halting at pc 3 -> RUN stops reason=1 with cycle_cnt=3; CLR_CNT -> cycle_cnt=0; RST mid-RUN -> all outputs reset.
//  6 CPU_RUN_WDOG_EN, WDOG_CYCLES=8, infinite loop prog -> stop reason=5, cycle_cnt=8.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller gating a per-cycle enable into the cpu core.
// Optional watchdog stop (reason 5) is built when CPU_RUN_WDOG_EN is defined.
module cpu_run_ctrl #(
    parameter int unsigned PC_WIDTH    = 16,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned NUM_BP      = 4,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic                                          CLK,
    input  logic                                          RST,
    input  logic                                          cmd_valid,
    output logic                                          cmd_ready,
    input  logic [1:0]                                    cmd_op,
    input  logic [CNT_WIDTH-1:0]                          cmd_steps,
    input  logic                                          bp_we,
    input  logic [((NUM_BP > 1) ? $clog2(NUM_BP) : 1)-1:0] bp_idx,
    input  logic [PC_WIDTH-1:0]                           bp_addr,
    input  logic                                          bp_on,
    input  logic [PC_WIDTH-1:0]                           cpu_pc,
    input  logic                                          cpu_halted,
    output logic                                          cpu_en,
    output logic                                          running,
    output logic                                          stop_pulse,
    output logic [2:0]                                    stop_reason,
    output logic [CNT_WIDTH-1:0]                          cycle_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_STEP    = 2'd2;
    localparam logic [1:0] ST_STOPPED = 2'd3;

    localparam logic [1:0] OP_RUN  = 2'd0;
    localparam logic [1:0] OP_STEP = 2'd1;
    localparam logic [1:0] OP_STOP = 2'd2;
    localparam logic [1:0] OP_CLR  = 2'd3;

    localparam logic [2:0] RSN_NONE = 3'd0;
    localparam logic [2:0] RSN_HALT = 3'd1;
    localparam logic [2:0] RSN_STEP = 3'd2;
    localparam logic [2:0] RSN_BP   = 3'd3;
    localparam logic [2:0] RSN_HOST = 3'd4;
    localparam logic [2:0] RSN_WDOG = 3'd5;

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                 first_q, first_d;
    logic [2:0]           stop_reason_q, stop_reason_d;
    logic                 stop_pulse_q, stop_pulse_d;
    logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [PC_WIDTH-1:0]  bp_addr_q [NUM_BP];
    logic [NUM_BP-1:0]    bp_on_q;

    logic       active_c;
    logic       host_stop_c;
    logic       bp_match_c;
    logic       bp_hit_c;
    logic       wdog_hit_c;
    logic       stop_hit_c;
    logic [2:0] stop_code_c;

    assign active_c    = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign host_stop_c = active_c && cmd_valid && (cmd_op == OP_STOP);

    // Breakpoint compare against registered slots, so a same-cycle write applies next cycle.
    always_comb begin
        bp_match_c = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_on_q[i] && (bp_addr_q[i] == cpu_pc)) begin
                bp_match_c = 1'b1;
            end
        end
    end

    assign bp_hit_c = active_c && !first_q && bp_match_c;

`ifdef CPU_RUN_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;

    assign wdog_hit_c = active_c && (wdog_q == WDOG_W'(WDOG_CYCLES));

    always_comb begin
        wdog_d = wdog_q;
        if (!active_c) begin
            wdog_d = '0;
        end else if (cpu_en) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_hit_c = 1'b0;
`endif

    // Stop priority: host > halt > breakpoint > watchdog; step_done handled separately.
    always_comb begin
        stop_hit_c  = 1'b1;
        stop_code_c = RSN_NONE;
        if (host_stop_c) begin
            stop_code_c = RSN_HOST;
        end else if (active_c && cpu_halted) begin
            stop_code_c = RSN_HALT;
        end else if (bp_hit_c) begin
            stop_code_c = RSN_BP;
        end else if (wdog_hit_c) begin
            stop_code_c = RSN_WDOG;
        end else begin
            stop_hit_c = 1'b0;
        end
    end

    assign cpu_en = active_c && !stop_hit_c;

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        first_d       = first_q;
        stop_reason_d = stop_reason_q;
        stop_pulse_d  = 1'b0;
        cycle_cnt_d   = cycle_cnt_q;

        if (cpu_en && (cycle_cnt_q != '1)) begin
            cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
        end

        case (state_q)
            ST_RUN, ST_STEP: begin
                first_d = 1'b0;
                if (stop_hit_c) begin
                    state_d       = ST_STOPPED;
                    stop_reason_d = stop_code_c;
                    stop_pulse_d  = 1'b1;
                end else if (state_q == ST_STEP) begin
                    if (remaining_q == CNT_WIDTH'(1)) begin
                        state_d       = ST_STOPPED;
                        stop_reason_d = RSN_STEP;
                        stop_pulse_d  = 1'b1;
                    end else begin
                        remaining_d = remaining_q - CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_RUN, OP_STEP: begin
                            if (cpu_halted) begin
                                state_d       = ST_STOPPED;
                                stop_reason_d = RSN_HALT;
                                stop_pulse_d  = 1'b1;
                            end else begin
                                state_d       = (cmd_op == OP_RUN) ? ST_RUN : ST_STEP;
                                stop_reason_d = RSN_NONE;
                                first_d       = 1'b1;
                                remaining_d   = (cmd_steps == '0) ? CNT_WIDTH'(1) : cmd_steps;
                            end
                        end
                        OP_CLR: cycle_cnt_d = '0;
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            remaining_q   <= '0;
            first_q       <= 1'b0;
            stop_reason_q <= RSN_NONE;
            stop_pulse_q  <= 1'b0;
            cycle_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            first_q       <= first_d;
            stop_reason_q <= stop_reason_d;
            stop_pulse_q  <= stop_pulse_d;
            cycle_cnt_q   <= cycle_cnt_d;
        end
    end

    // Breakpoint slot table; writes accepted in any state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bp_on_q <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr_q[i] <= '0;
            end
        end else if (bp_we && (32'(bp_idx) < NUM_BP)) begin
            bp_on_q[bp_idx]   <= bp_on;
            bp_addr_q[bp_idx] <= bp_addr;
        end
    end

    assign cmd_ready   = !active_c;
    assign running     = active_c;
    assign stop_pulse  = stop_pulse_q;
    assign stop_reason = stop_reason_q;
    assign cycle_cnt   = cycle_cnt_q;

endmodule
